// File: rtl/mem_copy_initiator_pkg.sv
// Shared types and constants for the memory copy/fill initiator.
package mem_copy_initiator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [3:0]  WSTRB_READ = 4'b0000;
    localparam logic [3:0]  WSTRB_WORD = 4'b1111;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    // One bus request as presented on the native memory interface.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    function automatic logic word_aligned(input logic [31:0] a);
        return a[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/mem_copy_initiator_mem_req_port.sv
// Request register stage: holds valid/addr/wdata/wstrb stable until the
// responder completes the transfer, and flags the handshake cycle.
module mem_req_port
    import mem_copy_initiator_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        load,
    input  mem_req_t    req,
    input  logic        mem_ready,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        hs
);

    assign hs = mem_valid & mem_ready;

    // Valid drops only on handshake; payload is loaded only while idle so it
    // cannot change under a stalled request.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (hs) begin
            mem_valid <= 1'b0;
        end else if (load && !mem_valid) begin
            mem_valid <= 1'b1;
            mem_addr  <= req.addr;
            mem_wdata <= req.wdata;
            mem_wstrb <= req.wstrb;
        end
    end

endmodule

// File: rtl/mem_copy_initiator.sv
// Copy/fill engine on the native memory interface. One command at a time;
// every bus handshake is followed by a single idle cycle.
module mem_copy_initiator
    import mem_copy_initiator_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_fill,
    input  logic [31:0]      cmd_src,
    input  logic [31:0]      cmd_dst,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      cmd_pattern,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata
);

    state_t           state, state_d;
    state_t           ret_q, ret_d;
    logic [31:0]      src_q, dst_q, pat_q, data_q;
    logic [LEN_W-1:0] rem_q;
    logic             fill_q;

    logic             accept, bad_cmd, hs, load;
    mem_req_t         req;

    assign accept  = cmd_valid & cmd_ready & (state == ST_IDLE);
    assign bad_cmd = !word_aligned(cmd_dst) || (!cmd_fill && !word_aligned(cmd_src));

    // Next state, return state after GAP, and the request to launch.
    always_comb begin
        state_d = state;
        ret_d   = ret_q;
        load    = 1'b0;
        req     = '{addr: dst_q, wdata: (fill_q ? pat_q : data_q), wstrb: WSTRB_WORD};
        case (state)
            ST_IDLE: begin
                if (accept && !bad_cmd) begin
                    if (cmd_len == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        load = 1'b1;
                        if (cmd_fill) begin
                            state_d = ST_WR;
                            req     = '{addr: cmd_dst, wdata: cmd_pattern, wstrb: WSTRB_WORD};
                        end else begin
                            state_d = ST_RD;
                            req     = '{addr: cmd_src, wdata: 32'h0, wstrb: WSTRB_READ};
                        end
                    end
                end
            end
            ST_RD: begin
                if (hs) begin
                    state_d = ST_GAP;
                    ret_d   = ST_WR;
                end
            end
            ST_WR: begin
                if (hs) begin
                    state_d = (rem_q == LEN_W'(1)) ? ST_DONE : ST_GAP;
                    ret_d   = fill_q ? ST_WR : ST_RD;
                end
            end
            ST_GAP: begin
                state_d = ret_q;
                load    = 1'b1;
                if (ret_q == ST_RD)
                    req = '{addr: src_q, wdata: 32'h0, wstrb: WSTRB_READ};
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= ST_IDLE;
            ret_q <= ST_IDLE;
        end else begin
            state <= state_d;
            ret_q <= ret_d;
        end
    end

    // Command latch, address/length counters and read-data capture.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            src_q  <= '0;
            dst_q  <= '0;
            pat_q  <= '0;
            data_q <= '0;
            rem_q  <= '0;
            fill_q <= 1'b0;
        end else begin
            if (accept && !bad_cmd) begin
                src_q  <= cmd_src;
                dst_q  <= cmd_dst;
                pat_q  <= cmd_pattern;
                rem_q  <= cmd_len;
                fill_q <= cmd_fill;
            end
            if (state == ST_RD && hs) begin
                data_q <= mem_rdata;
                src_q  <= src_q + WORD_BYTES;
            end
            if (state == ST_WR && hs) begin
                dst_q <= dst_q + WORD_BYTES;
                rem_q <= rem_q - LEN_W'(1);
            end
        end
    end

    // Registered status outputs, decoded from the state being entered.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            cmd_ready <= (state_d == ST_IDLE);
            busy      <= (state_d == ST_RD) || (state_d == ST_WR) || (state_d == ST_GAP);
            done      <= (state_d == ST_DONE);
            err       <= accept && bad_cmd;
        end
    end

    mem_req_port u_port (
        .clock     (clock),
        .resetn    (resetn),
        .load      (load),
        .req       (req),
        .mem_ready (mem_ready),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .hs        (hs)
    );

endmodule

// File: tb/tb_mem_copy_initiator.sv
// Scoreboard bench: a reference model expands each command into the expected
// bus transactions and completion event; a monitor checks them as they occur.
module tb_mem_copy_initiator;

    localparam int LEN_W = 16;

    logic             clock = 1'b0;
    logic             resetn = 1'b0;
    logic             cmd_valid, cmd_ready, cmd_fill;
    logic [31:0]      cmd_src, cmd_dst, cmd_pattern;
    logic [LEN_W-1:0] cmd_len;
    logic             busy, done, err;
    logic             mem_valid, mem_ready;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [3:0]       mem_wstrb;

    mem_copy_initiator #(.LEN_W(LEN_W)) dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fill(cmd_fill),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
        .busy(busy), .done(done), .err(err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus[$];
    int          exp_evt[$];            // 1 = done, 2 = err
    logic [31:0] sram    [logic [29:0]];
    logic [31:0] ref_mem [logic [29:0]];

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;
    int hs_count = 0;
    int stall_first = -1;
    int max_stall = 3;

    function automatic logic [31:0] sram_rd(input logic [31:0] a);
        return sram.exists(a[31:2]) ? sram[a[31:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : 32'h0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        sram[a[31:2]]    = v;
        ref_mem[a[31:2]] = v;
    endtask

    // Responder: random (or forced) wait states, read data valid with ready.
    int stall_left = 0;
    bit fresh = 1'b1;
    always @(posedge clock) begin
        #1;
        if (!mem_valid) begin
            mem_ready = 1'b0;
            fresh = 1'b1;
        end else begin
            if (fresh) begin
                fresh = 1'b0;
                if (stall_first >= 0) begin
                    stall_left  = stall_first;
                    stall_first = -1;
                end else begin
                    stall_left = $urandom_range(0, max_stall);
                end
            end
            if (stall_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = sram_rd(mem_addr);
            end else begin
                mem_ready = 1'b0;
                stall_left--;
            end
        end
    end

    // Monitor: protocol rules, bus scoreboard, completion events.
    logic [31:0] p_addr, p_wdata;
    logic [3:0]  p_wstrb;
    bit p_wait = 0, p_hs = 0, p_hs2 = 0, p_more = 0, p_more2 = 0;
    always @(negedge clock) begin
        bus_t e;
        int   ev;
        bit   hs_now;
        hs_now = mem_valid && mem_ready;
        if (mem_valid && mem_ready && mem_wstrb == 4'hF)
            sram[mem_addr[31:2]] = mem_wdata;
        if (mon_en) begin
            if (p_hs) check("gap_valid_low", mem_valid, 0);
            if (p_hs2 && p_more2) check("gap_one_cycle", mem_valid, 1);
            if (p_wait) begin
                check("stall_valid_held", mem_valid, 1);
                check("stall_addr", mem_addr, p_addr);
                check("stall_wdata", mem_wdata, p_wdata);
                check("stall_wstrb", mem_wstrb, p_wstrb);
            end
            if (mem_valid && exp_bus.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_request: addr=%h wstrb=%h, none expected", mem_addr, mem_wstrb);
            end
            if (hs_now && exp_bus.size() > 0) begin
                e = exp_bus.pop_front();
                hs_count++;
                check("bus_addr", mem_addr, e.addr);
                check("bus_wstrb", mem_wstrb, e.wstrb);
                if (e.wstrb == 4'hF) check("bus_wdata", mem_wdata, e.wdata);
            end
            if (done || err) begin
                if (exp_evt.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_event: done=%b err=%b, none expected", done, err);
                end else begin
                    ev = exp_evt.pop_front();
                    check("event_kind", {done, err}, (ev == 1) ? 2'b10 : 2'b01);
                    check("event_busy_low", busy, 0);
                    check("event_bus_drained", exp_bus.size(), 0);
                end
            end
            p_hs2   = p_hs;
            p_more2 = p_more;
            p_hs    = hs_now;
            p_more  = hs_now && exp_bus.size() > 0;
            p_wait  = mem_valid && !mem_ready;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
            p_wstrb = mem_wstrb;
        end else begin
            p_hs = 0; p_hs2 = 0; p_more = 0; p_more2 = 0; p_wait = 0;
        end
    end

    // Reference model: expand a command into bus traffic and its end event,
    // then drive it on the command port.
    task automatic issue(input bit fill, input logic [31:0] src, input logic [31:0] dst,
                         input logic [LEN_W-1:0] len, input logic [31:0] pat);
        int n = 0;
        int words = int'(len);
        if (dst[1:0] != 2'b00 || (!fill && src[1:0] != 2'b00)) begin
            exp_evt.push_back(2);
        end else begin
            for (int i = 0; i < words; i++) begin
                logic [31:0] s, d, w;
                s = src + 32'(i * 4);
                d = dst + 32'(i * 4);
                if (fill) begin
                    w = pat;
                end else begin
                    w = ref_rd(s);
                    exp_bus.push_back('{s, 4'h0, 32'h0});
                end
                exp_bus.push_back('{d, 4'hF, w});
                ref_mem[d[31:2]] = w;
            end
            exp_evt.push_back(1);
        end
        while (!cmd_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        cmd_fill = fill; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_pattern = pat;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_src = $urandom; cmd_dst = $urandom; cmd_pattern = $urandom;
    endtask

    task automatic wait_complete(input string name);
        int n = 0;
        while ((exp_bus.size() != 0 || exp_evt.size() != 0) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL %s_timeout: %0d bus / %0d events outstanding, required 0", name, exp_bus.size(), exp_evt.size());
            exp_bus.delete();
            exp_evt.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int base, n;
        cmd_valid = 0; cmd_fill = 0; cmd_src = 0; cmd_dst = 0; cmd_len = 0; cmd_pattern = 0;
        mem_ready = 0; mem_rdata = 0;

        // reset state
        repeat (3) @(negedge clock);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", mem_wstrb, 0);
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clock);
        check("cmd_ready_after_reset", cmd_ready, 1);

        // fill
        issue(1'b1, 32'h0, 32'h100, 4, 32'hA5A5A5A5);
        wait_complete("fill");
        for (int i = 0; i < 4; i++) check("fill_readback", sram_rd(32'h100 + 32'(i * 4)), 32'hA5A5A5A5);

        // copy
        preload(32'h0, 32'h11111111);
        preload(32'h4, 32'h22222222);
        issue(1'b0, 32'h0, 32'h200, 2, 32'h0);
        wait_complete("copy");
        check("copy_w200", sram_rd(32'h200), 32'h11111111);
        check("copy_w204", sram_rd(32'h204), 32'h22222222);

        // stall on the only write
        stall_first = 5;
        issue(1'b1, 32'h0, 32'h40, 1, 32'hDEADBEEF);
        wait_complete("stall");
        check("stall_readback", sram_rd(32'h40), 32'hDEADBEEF);

        // rejects and zero length
        issue(1'b1, 32'h0, 32'h102, 3, 32'h12345678);
        wait_complete("reject_dst");
        check("reject_cmd_ready", cmd_ready, 1);
        issue(1'b0, 32'h6, 32'h300, 2, 32'h0);
        wait_complete("reject_src");
        issue(1'b0, 32'h0, 32'h300, 0, 32'h0);
        wait_complete("zero_len");
        check("zero_len_cmd_ready", cmd_ready, 1);

        // address wrap
        issue(1'b1, 32'h0, 32'hFFFFFFFC, 2, 32'h13579BDF);
        wait_complete("wrap");
        check("wrap_hi", sram_rd(32'hFFFFFFFC), 32'h13579BDF);
        check("wrap_lo", sram_rd(32'h0), 32'h13579BDF);

        // randomized commands
        for (int i = 0; i < 64; i++) preload(32'h1000 + 32'(i * 4), $urandom);
        for (int k = 0; k < 30; k++) begin
            logic [31:0] s, d;
            bit f;
            f = 1'($urandom_range(0, 1));
            s = 32'h1000 + 32'($urandom_range(0, 40) * 4);
            d = 32'h1000 + 32'($urandom_range(0, 60) * 4);
            if ($urandom_range(0, 9) == 0) d[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 9) == 0) s[1:0] = 2'($urandom_range(1, 3));
            issue(f, s, d, LEN_W'($urandom_range(0, 6)), $urandom);
            wait_complete("random");
        end

        // reset in the middle of a copy
        max_stall = 0;
        base = hs_count;
        issue(1'b0, 32'h1000, 32'h3000, 8, 32'h0);
        n = 0;
        while (hs_count < base + 5 && n < 500) begin @(negedge clock); n++; end
        stall_first = 10;
        n = 0;
        while (!mem_valid && n < 20) begin @(negedge clock); n++; end
        check("midop_valid_before_reset", mem_valid, 1);
        resetn = 1'b0;
        mon_en = 1'b0;
        @(posedge clock);
        #1;
        check("midop_rst_mem_valid", mem_valid, 0);
        check("midop_rst_busy", busy, 0);
        check("midop_rst_cmd_ready", cmd_ready, 0);
        check("midop_rst_done", done, 0);
        repeat (3) begin
            @(negedge clock);
            check("midop_rst_no_done", done, 0);
        end
        exp_bus.delete();
        exp_evt.delete();
        ref_mem = sram;
        stall_first = -1;
        max_stall = 3;
        resetn = 1'b1;
        mon_en = 1'b1;
        @(negedge clock);
        check("midop_cmd_ready_after", cmd_ready, 1);
        check("midop_no_done_after", done, 0);
        issue(1'b1, 32'h0, 32'h3100, 1, 32'hCAFEF00D);
        wait_complete("post_reset_fill");
        check("post_reset_readback", sram_rd(32'h3100), 32'hCAFEF00D);

        // full memory sweep against the model
        foreach (ref_mem[k]) check("mem_sweep", sram_rd({k, 2'b00}), ref_mem[k]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
